// File: rtl/mem_bridge.sv
// mem_bridge: CPU load/store responder running one req/ack bus access per strobe, with timeout abort
module mem_bridge #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16,
    parameter int TIMEOUT   = 15,
    parameter int CNT_SIZE  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_load,
    input  logic                 req_store,
    input  logic                 req_io,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 done,
    output logic                 err,
    output logic                 busy,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic                 bus_io,
    output logic [ADDR_SIZE-1:0] bus_addr,
    output logic [WORD_SIZE-1:0] bus_wdata,
    input  logic [WORD_SIZE-1:0] bus_rdata,
    input  logic                 bus_ack
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
    localparam logic [CNT_SIZE-1:0] LP_LAST = CNT_SIZE'(TIMEOUT - 1);
    state_t               r_state, w_next;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_wdata, r_rdata;
    logic [CNT_SIZE-1:0]  r_cnt;
    logic                 r_we, r_io, r_err;
    logic                 w_start, w_illegal, w_busy, w_abort;
    assign w_start   = req_load ^ req_store;
    assign w_illegal = req_load & req_store;
    assign w_busy    = (r_state == S_REQ);
    // ack has priority: abort only fires when the last allowed cycle passes without ack
    assign w_abort   = w_busy & ~bus_ack & (r_cnt == LP_LAST);
    assign busy      = w_busy;
    assign bus_req   = w_busy;
    assign bus_we    = w_busy & r_we;
    assign bus_io    = w_busy & r_io;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign rdata     = r_rdata;
    assign done      = (r_state == S_DONE);
    assign err       = done & r_err;
    // state register; reset drops bus_req at once since bus_req decodes the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    // next state: strobes only matter in IDLE, so requests in REQ/DONE are dropped
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_start ? S_REQ : (w_illegal ? S_DONE : S_IDLE);
            S_REQ:   w_next = (bus_ack || w_abort) ? S_DONE : S_REQ;
            default: w_next = S_IDLE;
        endcase
    end
    // request latching, wait counting and load result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_io    <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_start) begin
                r_addr <= addr;
                r_we   <= req_store;
                r_io   <= req_io;
                r_cnt  <= '0;
                r_err  <= 1'b0;
                if (req_store) r_wdata <= wdata;
            end else if (w_illegal) begin
                r_err <= 1'b1;
            end
        end else if (w_busy) begin
            if (bus_ack) begin
                r_err <= 1'b0;
                if (!r_we) r_rdata <= bus_rdata;
            end else if (w_abort) begin
                r_err <= 1'b1;
                if (!r_we) r_rdata <= '1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed scoreboard bench for mem_bridge
module tb_mem_bridge;
    localparam int TO = 15;
    typedef struct {
        logic [15:0] rd;
        logic        err;
        int          reqc;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_load, req_store, req_io, bus_ack;
    logic [15:0] addr, wdata, bus_rdata;
    logic [15:0] rdata, bus_addr, bus_wdata;
    logic        done, err, busy, bus_req, bus_we, bus_io;
    logic [15:0] m_rdata;
    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    mem_bridge #(.WORD_SIZE(16), .ADDR_SIZE(16), .TIMEOUT(TO), .CNT_SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_load(req_load), .req_store(req_store),
        .req_io(req_io), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
        .err(err), .busy(busy), .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one strobe; device acks in bus_req cycle ack_at (0 = never); hold keeps the strobe up through REQ and DONE
    task automatic access(input string tag, input logic ld, input logic st, input logic io,
                          input logic [15:0] a, input logic [15:0] wd, input int ack_at,
                          input logic [15:0] rd, input bit hold);
        exp_t e;
        int   reqc = 0;
        bit   got = 0;
        bit   ok = (ack_at >= 1) && (ack_at <= TO);
        e.rd = m_rdata;
        if (ld && st) begin
            e.err  = 1'b1;
            e.reqc = 0;
        end else begin
            e.err  = !ok;
            e.reqc = ok ? ack_at : TO;
            if (ld) e.rd = ok ? rd : 16'hFFFF;
        end
        m_rdata = e.rd;
        @(negedge clk);
        req_load = ld; req_store = st; req_io = io; addr = a; wdata = wd;
        exp_q.push_back(e);
        @(negedge clk);
        if (!hold) begin
            req_load = 1'b0; req_store = 1'b0; req_io = 1'b0;
        end
        for (int k = 0; k < 40 && !got; k++) begin
            if (done) begin
                got = 1;
                bus_ack = 1'b0;
                e = exp_q.pop_front();
                chk({tag, "_rdata"}, rdata, e.rd);
                chk({tag, "_err"}, err, e.err);
                chk({tag, "_req_cycles"}, reqc, e.reqc);
                chk({tag, "_busy_in_done"}, busy, 0);
                chk({tag, "_req_in_done"}, bus_req, 0);
            end else begin
                if (bus_req) begin
                    reqc++;
                    chk({tag, "_bus_addr"}, bus_addr, a);
                    chk({tag, "_bus_we"}, bus_we, st);
                    chk({tag, "_bus_io"}, bus_io, io);
                    chk({tag, "_busy"}, busy, 1);
                    if (st) chk({tag, "_bus_wdata"}, bus_wdata, wd);
                end
                bus_ack = bus_req && (reqc == ack_at);
                bus_rdata = bus_ack ? rd : 16'($urandom);
                if (hold) addr = ~a;
                @(negedge clk);
            end
        end
        bus_ack = 1'b0;
        if (!got) chk({tag, "_done_seen"}, 0, 1);
        @(negedge clk);
        req_load = 1'b0; req_store = 1'b0; req_io = 1'b0;
        chk({tag, "_done_pulse_len"}, done, 0);
        chk({tag, "_no_restart"}, bus_req, 0);
        @(negedge clk);
        chk({tag, "_idle_after"}, bus_req, 0);
    endtask

    initial begin
        rst_n = 1'b0; req_load = 1'b0; req_store = 1'b0; req_io = 1'b0; bus_ack = 1'b0;
        addr = '0; wdata = '0; bus_rdata = '0; m_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_io", bus_io, 0);
        rst_n = 1'b1;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 16'hDEAD;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("idle_ack_rdata", rdata, 0);
        chk("idle_ack_done", done, 0);
        chk("idle_ack_req", bus_req, 0);
        access("zw_load", 1, 0, 0, 16'h0040, 16'h0000, 1, 16'hBEEF, 0);
        access("io_store", 0, 1, 1, 16'h0003, 16'h1234, 3, 16'h7777, 0);
        access("timeout", 1, 0, 0, 16'h0100, 16'h0000, 0, 16'h0000, 0);
        access("ack_at_limit", 1, 0, 1, 16'h0200, 16'h0000, TO, 16'h5A5A, 0);
        access("illegal", 1, 1, 0, 16'h0300, 16'h9999, 1, 16'h1111, 0);
        access("held_strobe", 1, 0, 0, 16'h0400, 16'h0000, 2, 16'hC3C3, 1);
        access("store_timeout", 0, 1, 0, 16'h0500, 16'hABCD, 0, 16'h0000, 0);
        chk("sb_empty", exp_q.size(), 0);
        @(negedge clk);
        req_load = 1'b1; addr = 16'h0600;
        @(negedge clk);
        req_load = 1'b0;
        chk("mid_rst_req_pre", bus_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bus_req", bus_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_bus_addr", bus_addr, 0);
        m_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 16'h4321;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("post_rst_rdata", rdata, m_rdata);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_req", bus_req, 0);
        chk("post_rst_done", done, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
